// File: rtl/ap_ctrl_perf_monitor.sv
// rtl/ap_ctrl_perf_monitor.sv - multi-channel ap_ctrl_hs latency/stall monitor with per-channel record dump
// Channel FSMs gather statistics until finish freezes them; then one record per channel streams out.
module ap_ctrl_perf_monitor #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 32,
  parameter int LAT_W = 24,
  localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              finish,
  input  logic              clear,
  input  logic [N_CH-1:0]   ch_start,
  input  logic [N_CH-1:0]   ch_ready,
  input  logic [N_CH-1:0]   ch_done,
  input  logic [N_CH-1:0]   ch_continue,
  output logic [N_CH-1:0]   busy,
  output logic [N_CH-1:0]   proto_err,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [IDX_W-1:0]  dump_ch,
  output logic [CNT_W-1:0]  dump_count,
  output logic [CNT_W-1:0]  dump_lat_sum,
  output logic [LAT_W-1:0]  dump_lat_min,
  output logic [LAT_W-1:0]  dump_lat_max,
  output logic [CNT_W-1:0]  dump_stall,
  output logic [2:0]        dump_flags,
  output logic              dump_last,
  output logic              all_done
);

  typedef enum logic [1:0] {CH_IDLE = 2'd0, CH_BUSY = 2'd1, CH_HOLD = 2'd2} ch_state_e;
  typedef enum logic [1:0] {DS_RUN = 2'd0, DS_DUMP = 2'd1, DS_END = 2'd2} dump_state_e;

  localparam logic [LAT_W-1:0] LAT_ONES = '1;
  localparam logic [CNT_W-1:0] CNT_ONES = '1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CH - 1);

  ch_state_e        st_q    [N_CH];
  ch_state_e        st_d    [N_CH];
  logic [LAT_W-1:0] lat_q   [N_CH];
  logic [LAT_W-1:0] lat_d   [N_CH];
  logic [LAT_W-1:0] min_q   [N_CH];
  logic [LAT_W-1:0] min_d   [N_CH];
  logic [LAT_W-1:0] max_q   [N_CH];
  logic [LAT_W-1:0] max_d   [N_CH];
  logic [CNT_W-1:0] cnt_q   [N_CH];
  logic [CNT_W-1:0] cnt_d   [N_CH];
  logic [CNT_W-1:0] sum_q   [N_CH];
  logic [CNT_W-1:0] sum_d   [N_CH];
  logic [CNT_W-1:0] stall_q [N_CH];
  logic [CNT_W-1:0] stall_d [N_CH];
  logic             ovf_q   [N_CH];
  logic             ovf_d   [N_CH];
  logic             perr_q  [N_CH];
  logic             perr_d  [N_CH];

  dump_state_e      ds_q, ds_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  // The edge that samples finish already holds everything, so records see pre-finish state.
  logic frozen;
  assign frozen = (ds_q != DS_RUN) || finish;

  logic             commit;
  logic [LAT_W-1:0] commit_lat;
  logic [LAT_W-1:0] lat_inc;
  logic [CNT_W:0]   sum_ext;

  always_comb begin
    commit     = 1'b0;
    commit_lat = '0;
    lat_inc    = '0;
    sum_ext    = '0;
    for (int c = 0; c < N_CH; c++) begin
      st_d[c]    = st_q[c];
      lat_d[c]   = lat_q[c];
      min_d[c]   = min_q[c];
      max_d[c]   = max_q[c];
      cnt_d[c]   = cnt_q[c];
      sum_d[c]   = sum_q[c];
      stall_d[c] = stall_q[c];
      ovf_d[c]   = ovf_q[c];
      perr_d[c]  = perr_q[c];
      commit     = 1'b0;
      commit_lat = '0;
      lat_inc    = (lat_q[c] == LAT_ONES) ? LAT_ONES : lat_q[c] + 1'b1;

      case (st_q[c])
        CH_IDLE: begin
          if (ch_start[c]) begin
            lat_d[c] = LAT_W'(1);
            if (ch_done[c] && ch_continue[c]) begin
              commit     = 1'b1;
              commit_lat = LAT_W'(1);
            end else if (ch_done[c]) begin
              st_d[c] = CH_HOLD;
            end else begin
              st_d[c] = CH_BUSY;
            end
          end else if (ch_done[c] || ch_ready[c]) begin
            perr_d[c] = 1'b1;
          end
        end
        CH_BUSY: begin
          lat_d[c] = lat_inc;
          if (lat_q[c] == LAT_ONES) ovf_d[c] = 1'b1;
          if (ch_done[c]) begin
            if (ch_continue[c]) begin
              commit     = 1'b1;
              commit_lat = lat_inc;
              st_d[c]    = CH_IDLE;
            end else begin
              st_d[c] = CH_HOLD;
            end
          end
        end
        CH_HOLD: begin
          if (stall_q[c] == CNT_ONES) ovf_d[c] = 1'b1;
          else                        stall_d[c] = stall_q[c] + 1'b1;
          if (ch_continue[c]) begin
            commit     = 1'b1;
            commit_lat = lat_q[c];
            st_d[c]    = CH_IDLE;
          end
        end
        default: st_d[c] = CH_IDLE;
      endcase

      if (commit) begin
        if (cnt_q[c] == CNT_ONES) ovf_d[c] = 1'b1;
        else                      cnt_d[c] = cnt_q[c] + 1'b1;
        sum_ext = {1'b0, sum_q[c]} + {{(CNT_W + 1 - LAT_W){1'b0}}, commit_lat};
        if (sum_ext[CNT_W]) begin
          sum_d[c] = CNT_ONES;
          ovf_d[c] = 1'b1;
        end else begin
          sum_d[c] = sum_ext[CNT_W-1:0];
        end
        if (commit_lat < min_q[c]) min_d[c] = commit_lat;
        if (commit_lat > max_q[c]) max_d[c] = commit_lat;
      end

      // Clear resets statistics only; handshake tracking and in-flight latency carry on.
      if (clear) begin
        cnt_d[c]   = '0;
        sum_d[c]   = '0;
        min_d[c]   = LAT_ONES;
        max_d[c]   = '0;
        stall_d[c] = '0;
        ovf_d[c]   = 1'b0;
        perr_d[c]  = 1'b0;
      end

      if (frozen) begin
        st_d[c]    = st_q[c];
        lat_d[c]   = lat_q[c];
        min_d[c]   = min_q[c];
        max_d[c]   = max_q[c];
        cnt_d[c]   = cnt_q[c];
        sum_d[c]   = sum_q[c];
        stall_d[c] = stall_q[c];
        ovf_d[c]   = ovf_q[c];
        perr_d[c]  = perr_q[c];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < N_CH; c++) begin
        st_q[c]    <= CH_IDLE;
        lat_q[c]   <= '0;
        min_q[c]   <= LAT_ONES;
        max_q[c]   <= '0;
        cnt_q[c]   <= '0;
        sum_q[c]   <= '0;
        stall_q[c] <= '0;
        ovf_q[c]   <= 1'b0;
        perr_q[c]  <= 1'b0;
      end
      ds_q  <= DS_RUN;
      idx_q <= '0;
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        st_q[c]    <= st_d[c];
        lat_q[c]   <= lat_d[c];
        min_q[c]   <= min_d[c];
        max_q[c]   <= max_d[c];
        cnt_q[c]   <= cnt_d[c];
        sum_q[c]   <= sum_d[c];
        stall_q[c] <= stall_d[c];
        ovf_q[c]   <= ovf_d[c];
        perr_q[c]  <= perr_d[c];
      end
      ds_q  <= ds_d;
      idx_q <= idx_d;
    end
  end

  always_comb begin
    ds_d  = ds_q;
    idx_d = idx_q;
    case (ds_q)
      DS_RUN: begin
        if (finish) begin
          ds_d  = DS_DUMP;
          idx_d = '0;
        end
      end
      DS_DUMP: begin
        if (dump_ready) begin
          if (idx_q == LAST_IDX) ds_d = DS_END;
          else                   idx_d = idx_q + 1'b1;
        end
      end
      DS_END:  ds_d = DS_END;
      default: ds_d = DS_RUN;
    endcase
  end

  // Record fields are gated so idle outputs read as zero.
  always_comb begin
    dump_valid   = (ds_q == DS_DUMP);
    all_done     = (ds_q == DS_END);
    dump_ch      = '0;
    dump_count   = '0;
    dump_lat_sum = '0;
    dump_lat_min = '0;
    dump_lat_max = '0;
    dump_stall   = '0;
    dump_flags   = '0;
    dump_last    = 1'b0;
    if (ds_q == DS_DUMP) begin
      dump_ch      = idx_q;
      dump_count   = cnt_q[idx_q];
      dump_lat_sum = sum_q[idx_q];
      dump_lat_min = (cnt_q[idx_q] == '0) ? '0 : min_q[idx_q];
      dump_lat_max = max_q[idx_q];
      dump_stall   = stall_q[idx_q];
      dump_flags   = {st_q[idx_q] != CH_IDLE, ovf_q[idx_q], perr_q[idx_q]};
      dump_last    = (idx_q == LAST_IDX);
    end
  end

  always_comb begin
    busy      = '0;
    proto_err = '0;
    for (int c = 0; c < N_CH; c++) begin
      busy[c]      = (st_q[c] != CH_IDLE);
      proto_err[c] = perr_q[c];
    end
  end

endmodule

// File: tb/tb_ap_ctrl_perf_monitor.sv
// tb/tb_ap_ctrl_perf_monitor.sv - self-checking bench for ap_ctrl_perf_monitor
// Directed scenarios plus randomized traffic against a timestamp-based reference model.
module tb_ap_ctrl_perf_monitor;
  localparam int N_CH    = 4;
  localparam int CNT_W   = 32;
  localparam int LAT_W   = 24;
  localparam int IDX_W   = 2;
  localparam int S_CNT_W = 8;
  localparam int S_LAT_W = 4;
  localparam int unsigned M_LAT_MAX = (1 << LAT_W) - 1;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic             reset, finish, clear, dump_ready;
  logic [N_CH-1:0]  ch_start, ch_ready, ch_done, ch_continue;
  logic [N_CH-1:0]  busy, proto_err;
  logic             dump_valid, dump_last, all_done;
  logic [IDX_W-1:0] dump_ch;
  logic [CNT_W-1:0] dump_count, dump_lat_sum, dump_stall;
  logic [LAT_W-1:0] dump_lat_min, dump_lat_max;
  logic [2:0]       dump_flags;

  logic               s_finish, s_clear, s_dump_ready;
  logic [0:0]         s_start, s_ready, s_done, s_continue, s_busy, s_proto_err;
  logic               s_dump_valid, s_dump_last, s_all_done;
  logic [0:0]         s_dump_ch;
  logic [S_CNT_W-1:0] s_dump_count, s_dump_lat_sum, s_dump_stall;
  logic [S_LAT_W-1:0] s_dump_lat_min, s_dump_lat_max;
  logic [2:0]         s_dump_flags;

  ap_ctrl_perf_monitor #(.N_CH(N_CH), .CNT_W(CNT_W), .LAT_W(LAT_W)) dut (
    .clock(clock), .reset(reset), .finish(finish), .clear(clear),
    .ch_start(ch_start), .ch_ready(ch_ready), .ch_done(ch_done), .ch_continue(ch_continue),
    .busy(busy), .proto_err(proto_err), .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_ch(dump_ch), .dump_count(dump_count), .dump_lat_sum(dump_lat_sum),
    .dump_lat_min(dump_lat_min), .dump_lat_max(dump_lat_max), .dump_stall(dump_stall),
    .dump_flags(dump_flags), .dump_last(dump_last), .all_done(all_done)
  );

  ap_ctrl_perf_monitor #(.N_CH(1), .CNT_W(S_CNT_W), .LAT_W(S_LAT_W)) dut_s (
    .clock(clock), .reset(reset), .finish(s_finish), .clear(s_clear),
    .ch_start(s_start), .ch_ready(s_ready), .ch_done(s_done), .ch_continue(s_continue),
    .busy(s_busy), .proto_err(s_proto_err), .dump_valid(s_dump_valid), .dump_ready(s_dump_ready),
    .dump_ch(s_dump_ch), .dump_count(s_dump_count), .dump_lat_sum(s_dump_lat_sum),
    .dump_lat_min(s_dump_lat_min), .dump_lat_max(s_dump_lat_max), .dump_stall(s_dump_stall),
    .dump_flags(s_dump_flags), .dump_last(s_dump_last), .all_done(s_all_done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: per-channel phase (0 idle, 1 running, 2 awaiting continue) with start timestamps.
  int unsigned m_cnt[N_CH], m_sum[N_CH], m_min[N_CH], m_max[N_CH], m_stall[N_CH], m_lat[N_CH];
  int          m_phase[N_CH], m_tstart[N_CH];
  bit          m_ovf[N_CH], m_perr[N_CH];
  bit          m_frozen;
  int          t_now = 0;

  task automatic model_reset();
    for (int c = 0; c < N_CH; c++) begin
      m_cnt[c] = 0; m_sum[c] = 0; m_min[c] = M_LAT_MAX; m_max[c] = 0; m_stall[c] = 0;
      m_lat[c] = 0; m_phase[c] = 0; m_tstart[c] = 0; m_ovf[c] = 0; m_perr[c] = 0;
    end
    m_frozen = 0;
  endtask

  task automatic model_commit(input int c, input int unsigned l);
    m_cnt[c]++;
    m_sum[c] += l;
    if (l < m_min[c]) m_min[c] = l;
    if (l > m_max[c]) m_max[c] = l;
  endtask

  task automatic model_step();
    int unsigned elapsed;
    if (m_frozen || finish) begin
      m_frozen = 1;
      return;
    end
    for (int c = 0; c < N_CH; c++) begin
      if (m_phase[c] == 0) begin
        if (ch_start[c]) begin
          m_tstart[c] = t_now;
          if (ch_done[c] && ch_continue[c]) model_commit(c, 1);
          else if (ch_done[c]) begin m_lat[c] = 1; m_phase[c] = 2; end
          else m_phase[c] = 1;
        end else if (ch_done[c] || ch_ready[c]) begin
          m_perr[c] = 1;
        end
      end else if (m_phase[c] == 1) begin
        elapsed = int'(t_now - m_tstart[c] + 1);
        if (elapsed > M_LAT_MAX) begin m_ovf[c] = 1; elapsed = M_LAT_MAX; end
        if (ch_done[c]) begin
          if (ch_continue[c]) begin model_commit(c, elapsed); m_phase[c] = 0; end
          else begin m_lat[c] = elapsed; m_phase[c] = 2; end
        end
      end else begin
        m_stall[c]++;
        if (ch_continue[c]) begin model_commit(c, m_lat[c]); m_phase[c] = 0; end
      end
      if (clear) begin
        m_cnt[c] = 0; m_sum[c] = 0; m_min[c] = M_LAT_MAX; m_max[c] = 0; m_stall[c] = 0;
        m_ovf[c] = 0; m_perr[c] = 0;
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clock);
    #1;
    t_now++;
  endtask

  task automatic do_reset();
    reset = 1; finish = 0; clear = 0; dump_ready = 0;
    ch_start = '0; ch_ready = '0; ch_done = '0; ch_continue = '1;
    s_finish = 0; s_clear = 0; s_dump_ready = 0;
    s_start = '0; s_ready = '0; s_done = '0; s_continue = '1;
    model_reset();
    @(posedge clock);
    #1;
    reset = 0;
  endtask

  logic [CNT_W-1:0] r_count[N_CH], r_sum[N_CH], r_stall[N_CH];
  logic [LAT_W-1:0] r_min[N_CH], r_max[N_CH];
  logic [2:0]       r_flags[N_CH];
  logic [IDX_W-1:0] r_ch[N_CH];
  logic             r_last[N_CH];
  int               r_n;

  // Collects accepted records only; every test judges them itself.
  task automatic collect(input bit rand_ready);
    r_n = 0;
    for (int cyc = 0; cyc < 200 && r_n < N_CH; cyc++) begin
      dump_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (dump_valid && dump_ready) begin
        r_count[r_n] = dump_count; r_sum[r_n] = dump_lat_sum; r_stall[r_n] = dump_stall;
        r_min[r_n] = dump_lat_min; r_max[r_n] = dump_lat_max; r_flags[r_n] = dump_flags;
        r_ch[r_n] = dump_ch; r_last[r_n] = dump_last;
        r_n++;
      end
      tick();
    end
    dump_ready = 0;
  endtask

  task automatic start_dump();
    finish = 1;
    tick();
    finish = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (dump_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b expected 0", dump_valid); end
    n_checks++; if (all_done !== 1'b0) begin n_fail++; $display("FAIL reset_all_done: got %0b expected 0", all_done); end
    n_checks++; if (busy !== '0 || proto_err !== '0) begin n_fail++; $display("FAIL reset_busy_err: got %0h/%0h expected 0/0", busy, proto_err); end
    n_checks++; if ({dump_count, dump_lat_min, dump_flags, dump_last} !== '0) begin n_fail++; $display("FAIL reset_fields: got cnt %0d min %0d flags %0d expected 0", dump_count, dump_lat_min, dump_flags); end
    n_checks++; if (s_dump_valid !== 1'b0 || s_all_done !== 1'b0) begin n_fail++; $display("FAIL reset_small: got %0b/%0b expected 0/0", s_dump_valid, s_all_done); end
  endtask

  task automatic test_single_txn();
    do_reset();
    ch_start[0] = 1; tick(); ch_start[0] = 0;
    repeat (3) tick();
    ch_done[0] = 1; tick(); ch_done[0] = 0;
    tick();
    start_dump();
    collect(1'b1);
    n_checks++; if (r_n !== N_CH) begin n_fail++; $display("FAIL single_records: got %0d expected %0d", r_n, N_CH); end
    n_checks++; if ({r_count[0], r_sum[0], r_stall[0]} !== {32'd1, 32'd5, 32'd0}) begin n_fail++; $display("FAIL single_cnt_sum_stall: got %0d/%0d/%0d expected 1/5/0", r_count[0], r_sum[0], r_stall[0]); end
    n_checks++; if (r_min[0] !== 24'd5 || r_max[0] !== 24'd5) begin n_fail++; $display("FAIL single_minmax: got %0d/%0d expected 5/5", r_min[0], r_max[0]); end
    n_checks++; if (r_count[1] !== '0 || r_min[1] !== '0 || r_flags[1] !== 3'b000) begin n_fail++; $display("FAIL single_idle_ch: got %0d/%0d/%0d expected 0/0/0", r_count[1], r_min[1], r_flags[1]); end
  endtask

  task automatic test_hold();
    do_reset();
    ch_start[1] = 1; tick(); ch_start[1] = 0;
    repeat (2) tick();
    ch_done[1] = 1; ch_continue[1] = 0; tick(); ch_done[1] = 0;
    n_checks++; if (busy[1] !== 1'b1) begin n_fail++; $display("FAIL hold_busy: got %0b expected 1", busy[1]); end
    repeat (2) tick();
    ch_continue[1] = 1; tick();
    n_checks++; if (busy[1] !== 1'b0) begin n_fail++; $display("FAIL hold_release: got %0b expected 0", busy[1]); end
    start_dump();
    collect(1'b0);
    n_checks++; if ({r_count[1], r_sum[1], r_stall[1]} !== {32'd1, 32'd4, 32'd3}) begin n_fail++; $display("FAIL hold_cnt_sum_stall: got %0d/%0d/%0d expected 1/4/3", r_count[1], r_sum[1], r_stall[1]); end
    n_checks++; if (r_max[1] !== 24'd4 || r_flags[1] !== 3'b000) begin n_fail++; $display("FAIL hold_max_flags: got %0d/%0d expected 4/0", r_max[1], r_flags[1]); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    ch_start[2] = 1; ch_done[2] = 1;
    repeat (10) tick();
    ch_start[2] = 0; ch_done[2] = 0;
    start_dump();
    collect(1'b1);
    n_checks++; if ({r_count[2], r_sum[2]} !== {32'd10, 32'd10}) begin n_fail++; $display("FAIL b2b_cnt_sum: got %0d/%0d expected 10/10", r_count[2], r_sum[2]); end
    n_checks++; if (r_min[2] !== 24'd1 || r_max[2] !== 24'd1) begin n_fail++; $display("FAIL b2b_minmax: got %0d/%0d expected 1/1", r_min[2], r_max[2]); end
  endtask

  task automatic test_overflow_proto();
    do_reset();
    s_start = 1; tick(); s_start = 0;
    repeat (20) tick();
    s_done = 1; tick();
    tick();
    s_done = 0;
    n_checks++; if (s_proto_err !== 1'b1) begin n_fail++; $display("FAIL small_proto_err: got %0b expected 1", s_proto_err); end
    s_finish = 1; tick(); s_finish = 0;
    n_checks++; if (s_dump_valid !== 1'b1 || s_dump_ch !== 1'b0 || s_dump_last !== 1'b1) begin n_fail++; $display("FAIL small_record: got v%0b ch%0d last%0b expected 1/0/1", s_dump_valid, s_dump_ch, s_dump_last); end
    n_checks++; if (s_dump_lat_max !== 4'd15 || s_dump_lat_sum !== 8'd15 || s_dump_count !== 8'd1) begin n_fail++; $display("FAIL small_sat_lat: got max %0d sum %0d cnt %0d expected 15/15/1", s_dump_lat_max, s_dump_lat_sum, s_dump_count); end
    n_checks++; if (s_dump_flags !== 3'b011) begin n_fail++; $display("FAIL small_flags: got %0b expected 011", s_dump_flags); end
    s_dump_ready = 1; tick(); s_dump_ready = 0;
    n_checks++; if (s_all_done !== 1'b1 || s_dump_valid !== 1'b0) begin n_fail++; $display("FAIL small_all_done: got %0b/%0b expected 1/0", s_all_done, s_dump_valid); end
  endtask

  task automatic test_clear();
    do_reset();
    ch_start[1] = 1; ch_done[3] = 1; tick();
    ch_start[1] = 0; ch_done[3] = 0;
    n_checks++; if (proto_err !== 4'b1000) begin n_fail++; $display("FAIL clear_perr_set: got %0b expected 1000", proto_err); end
    ch_start[0] = 1; tick(); ch_start[0] = 0;
    ch_done[0] = 1; clear = 1; tick(); ch_done[0] = 0; clear = 0;
    n_checks++; if (proto_err !== 4'b0000 || busy !== 4'b0010) begin n_fail++; $display("FAIL clear_state: got err %0b busy %0b expected 0000/0010", proto_err, busy); end
    ch_done[1] = 1; tick(); ch_done[1] = 0;
    start_dump();
    clear = 1;
    collect(1'b1);
    clear = 0;
    n_checks++; if (r_count[0] !== '0 || r_min[0] !== '0) begin n_fail++; $display("FAIL clear_wins_commit: got %0d/%0d expected 0/0", r_count[0], r_min[0]); end
    n_checks++; if ({r_count[1], r_sum[1]} !== {32'd1, 32'd4}) begin n_fail++; $display("FAIL clear_inflight_lat: got %0d/%0d expected 1/4", r_count[1], r_sum[1]); end
  endtask

  task automatic test_random();
    logic [2:0] exp_flags;
    int unsigned exp_min;
    for (int run = 0; run < 2; run++) begin
      do_reset();
      for (int cyc = 0; cyc < 400; cyc++) begin
        for (int c = 0; c < N_CH; c++) begin
          ch_start[c]    = ($urandom % 3) == 0;
          ch_done[c]     = ($urandom % 4) == 0;
          ch_continue[c] = ($urandom % 2) == 0;
          ch_ready[c]    = ($urandom % 16) == 0;
        end
        clear = ($urandom % 40) == 0;
        tick();
      end
      ch_start = '0; ch_done = '0; ch_ready = '0; clear = 0;
      start_dump();
      collect(1'b1);
      n_checks++; if (r_n !== N_CH) begin n_fail++; $display("FAIL rand_records: got %0d expected %0d", r_n, N_CH); end
      for (int k = 0; k < N_CH; k++) begin
        exp_flags = {m_phase[k] != 0, m_ovf[k], m_perr[k]};
        exp_min   = (m_cnt[k] == 0) ? 0 : m_min[k];
        n_checks++; if (r_count[k] !== m_cnt[k] || r_sum[k] !== m_sum[k]) begin n_fail++; $display("FAIL rand_cnt_sum ch%0d: got %0d/%0d expected %0d/%0d", k, r_count[k], r_sum[k], m_cnt[k], m_sum[k]); end
        n_checks++; if (r_min[k] !== LAT_W'(exp_min) || r_max[k] !== LAT_W'(m_max[k])) begin n_fail++; $display("FAIL rand_minmax ch%0d: got %0d/%0d expected %0d/%0d", k, r_min[k], r_max[k], exp_min, m_max[k]); end
        n_checks++; if (r_stall[k] !== m_stall[k]) begin n_fail++; $display("FAIL rand_stall ch%0d: got %0d expected %0d", k, r_stall[k], m_stall[k]); end
        n_checks++; if (r_flags[k] !== exp_flags) begin n_fail++; $display("FAIL rand_flags ch%0d: got %0b expected %0b", k, r_flags[k], exp_flags); end
        n_checks++; if (r_ch[k] !== IDX_W'(k) || r_last[k] !== (k == N_CH - 1)) begin n_fail++; $display("FAIL rand_order ch%0d: got ch%0d last%0b", k, r_ch[k], r_last[k]); end
      end
    end
  endtask

  task automatic test_dump_stall();
    do_reset();
    ch_start[0] = 1; tick(); ch_start[0] = 0;
    ch_done[0] = 1; tick(); ch_done[0] = 0;
    ch_start[2] = 1; tick(); ch_start[2] = 0;
    tick();
    start_dump();
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (dump_valid !== 1'b1 || dump_ch !== 2'd0 || dump_count !== 32'd1 || dump_lat_sum !== 32'd2) begin n_fail++; $display("FAIL dump_hold_stable cyc%0d: got v%0b ch%0d cnt%0d sum%0d expected 1/0/1/2", i, dump_valid, dump_ch, dump_count, dump_lat_sum); end
      tick();
    end
    collect(1'b0);
    n_checks++; if (r_n !== N_CH) begin n_fail++; $display("FAIL dump_records: got %0d expected %0d", r_n, N_CH); end
    for (int k = 0; k < N_CH; k++) begin
      n_checks++; if (r_ch[k] !== IDX_W'(k) || r_last[k] !== (k == N_CH - 1)) begin n_fail++; $display("FAIL dump_order rec%0d: got ch%0d last%0b", k, r_ch[k], r_last[k]); end
    end
    n_checks++; if (r_flags[2] !== 3'b100 || r_count[2] !== '0) begin n_fail++; $display("FAIL dump_pending: got flags %0b cnt %0d expected 100/0", r_flags[2], r_count[2]); end
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (all_done !== 1'b1 || dump_valid !== 1'b0) begin n_fail++; $display("FAIL dump_all_done: got %0b/%0b expected 1/0", all_done, dump_valid); end
      tick();
    end
  endtask

  task automatic test_reset_mid_dump();
    do_reset();
    ch_start[0] = 1; tick(); ch_start[0] = 0;
    ch_done[0] = 1; ch_done[1] = 1; ch_start[3] = 1; tick();
    ch_done = '0; ch_start = '0;
    start_dump();
    dump_ready = 1; tick(); tick(); dump_ready = 0;
    n_checks++; if (dump_ch !== 2'd2 || busy !== 4'b1000 || proto_err !== 4'b0010) begin n_fail++; $display("FAIL mid_pre: got ch%0d busy %0b err %0b expected 2/1000/0010", dump_ch, busy, proto_err); end
    #2;
    reset = 1;
    #1;
    n_checks++; if (dump_valid !== 1'b0 || all_done !== 1'b0 || busy !== '0 || proto_err !== '0 || dump_count !== '0 || dump_ch !== '0) begin n_fail++; $display("FAIL mid_async_reset: got v%0b ad%0b busy %0b err %0b cnt %0d", dump_valid, all_done, busy, proto_err, dump_count); end
    do_reset();
    repeat (3) tick();
    n_checks++; if (dump_valid !== 1'b0 || all_done !== 1'b0) begin n_fail++; $display("FAIL mid_no_restart: got %0b/%0b expected 0/0", dump_valid, all_done); end
    start_dump();
    collect(1'b1);
    n_checks++; if (r_n !== N_CH || r_count[0] !== '0 || r_flags[3] !== 3'b000 || r_flags[1] !== 3'b000) begin n_fail++; $display("FAIL mid_stats_cleared: got n%0d cnt %0d flags %0b/%0b expected 4/0/0/0", r_n, r_count[0], r_flags[3], r_flags[1]); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_txn();
    test_hold();
    test_back_to_back();
    test_overflow_proto();
    test_clear();
    test_random();
    test_dump_stall();
    test_reset_mid_dump();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
